// File: rtl/seg_top.sv
// Free-running 32-bit hex counter on an 8-digit seven-segment display behind a serial shift-register chain.
// A frame takes 1 LOAD + 128*SHIFT_DIV SHIFT + 1 DONE cycles; requests that arrive mid-frame collapse into one pending.
module seg_top #(
  parameter int unsigned CNT_DIV   = 1_000_000,
  parameter int unsigned SHIFT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sysclk_n,
  output logic SEGCLK,
  output logic SEGDT,
  output logic SEGCLR,
  output logic SEGEN
);

  localparam int unsigned PW = (CNT_DIV > 2) ? $clog2(CNT_DIV) : 1;
  localparam int unsigned DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The negative clock leg only exists to terminate the differential pair.
  logic unused_sysclk_n;
  assign unused_sysclk_n = sysclk_n;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   value_q, value_d;
  logic          started_q, started_d;
  logic          pending_q, pending_d;
  state_t        state_q, state_d;
  logic [62:0]   shreg_q, shreg_d;
  logic [5:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          segclk_q, segclk_d;
  logic          segdt_q, segdt_d;
  logic          segen_q, segen_d;
  logic          segclr_q, segclr_d;

  logic          tick;
  logic          req_any;
  logic          div_end;
  logic          last_fall;
  logic [63:0]   frame;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Digit 7 lands in the top byte so it leaves the chain first.
  always_comb begin
    frame = '0;
    for (int i = 0; i < 8; i++) begin
      frame[8*i +: 8] = hex_to_seg(value_q[4*i +: 4]);
    end
  end

  always_comb begin
    tick      = (presc_q == PW'(CNT_DIV - 1));
    presc_d   = tick ? '0 : presc_q + PW'(1);
    value_d   = tick ? value_q + 32'd1 : value_q;
    started_d = 1'b1;
    segclr_d  = 1'b1;
  end

  // The very first cycle out of reset requests a frame without waiting a full CNT_DIV period.
  assign req_any   = tick | ~started_q | pending_q;
  assign div_end   = (div_q == DW'(SHIFT_DIV - 1));
  assign last_fall = segclk_q & div_end & (bit_q == 6'd63);

  always_comb begin
    pending_d = pending_q;
    if (state_q == S_IDLE) begin
      pending_d = 1'b0;
    end else if (tick) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_any) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (last_fall) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    segclk_d = segclk_q;
    segdt_d  = segdt_q;
    segen_d  = segen_q;
    unique case (state_q)
      S_LOAD: begin
        shreg_d  = frame[62:0];
        segdt_d  = frame[63];
        bit_d    = '0;
        div_d    = '0;
        segclk_d = 1'b0;
      end
      S_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (!segclk_q) begin
            segclk_d = 1'b1;
          end else begin
            // Falling edge: present the next bit so it gets a full low half of setup.
            segclk_d = 1'b0;
            if (bit_q != 6'd63) begin
              bit_d   = bit_q + 6'd1;
              segdt_d = shreg_q[62];
              shreg_d = {shreg_q[61:0], 1'b0};
            end else begin
              segen_d = 1'b1;
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q   <= '0;
      value_q   <= '0;
      started_q <= 1'b0;
      pending_q <= 1'b0;
      shreg_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      segclk_q  <= 1'b0;
      segdt_q   <= 1'b0;
      segen_q   <= 1'b0;
      segclr_q  <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      value_q   <= value_d;
      started_q <= started_d;
      pending_q <= pending_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      segclk_q  <= segclk_d;
      segdt_q   <= segdt_d;
      segen_q   <= segen_d;
      segclr_q  <= segclr_d;
    end
  end

  assign SEGCLK = segclk_q;
  assign SEGDT  = segdt_q;
  assign SEGCLR = segclr_q;
  assign SEGEN  = segen_q;

endmodule

// File: tb/tb_seg_top.sv
// Bench for seg_top: a slow instance (CNT_DIV=1000) and a fast one (CNT_DIV=50) share clock and reset.
// Expected frames are queued by the stimulus; per-instance monitors rebuild frames from SEGCLK/SEGDT and compare.
`timescale 1ns/1ps
module tb_seg_top;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sysclk_n;
  logic s_clk, s_dt, s_clr, s_en;
  logic f_clk, f_dt, f_clr, f_en;

  always #5 clk = ~clk;
  assign sysclk_n = ~clk;

  seg_top #(.CNT_DIV(1000), .SHIFT_DIV(1)) dut_s (
    .clk(clk), .rst(rst), .sysclk_n(sysclk_n),
    .SEGCLK(s_clk), .SEGDT(s_dt), .SEGCLR(s_clr), .SEGEN(s_en)
  );

  seg_top #(.CNT_DIV(50), .SHIFT_DIV(1)) dut_f (
    .clk(clk), .rst(rst), .sysclk_n(sysclk_n),
    .SEGCLK(f_clk), .SEGDT(f_dt), .SEGCLR(f_clr), .SEGEN(f_en)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_s[$];
  logic [63:0] exp_f[$];

  localparam logic [63:0] FR_ZERO = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] FR_ONE  = 64'hC0C0_C0C0_C0C0_C0F9;
  localparam logic [63:0] FR_MIX  = 64'h8090_8883_C6A1_868E;
  localparam logic [63:0] FR_FFFF = 64'h8E8E_8E8E_8E8E_8E8E;
  localparam logic [63:0] FR_TWO  = 64'hC0C0_C0C0_C0C0_C0A4;
  localparam logic [63:0] FR_FIVE = 64'hC0C0_C0C0_C0C0_C092;
  localparam logic [63:0] FR_SEVN = 64'hC0C0_C0C0_C0C0_C0F8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Slow-instance monitor: frame contents, first-edge timing and SEGEN behaviour.
  int          s_cyc = -1;
  int          s_bits = 0;
  logic [63:0] s_sh = '0;
  logic        s_prev = 1'b0;
  logic        s_seen = 1'b0;
  logic        s_wait_en = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      s_cyc = -1; s_bits = 0; s_prev = 1'b0; s_seen = 1'b0; s_wait_en = 1'b0;
    end else begin
      s_cyc++;
      if (s_wait_en) begin
        check("segen_after_frame", 64'(s_en), 64'd1);
        check("segclk_low_after_frame", 64'(s_clk), 64'd0);
        s_wait_en = 1'b0;
      end
      if (s_clk && !s_prev) begin
        if (s_bits == 0 && !s_seen) check("first_rise_cycle", 64'(s_cyc), 64'd3);
        s_sh = {s_sh[62:0], s_dt};
        s_bits++;
        if (s_bits == 64) begin
          if (!s_seen) check("segen_low_before_first_done", 64'(s_en), 64'd0);
          if (exp_s.size() == 0) begin
            checks++; errors++;
            $display("FAIL slow_frame: got unexpected frame %h, expected none", s_sh);
          end else begin
            check("slow_frame", s_sh, exp_s.pop_front());
          end
          s_bits = 0; s_seen = 1'b1; s_wait_en = 1'b1;
        end
      end
      s_prev = s_clk;
    end
  end

  // Fast-instance monitor: first four frames only, with bit spacing and inter-frame gap.
  int          f_cyc = -1;
  int          f_bits = 0;
  int          f_frames = 0;
  int          f_last = 0;
  logic        f_space_ok = 1'b1;
  logic [63:0] f_sh = '0;
  logic        f_prev = 1'b0;

  always @(negedge clk) begin
    if (f_frames < 4) begin
      if (!rst) begin
        f_cyc = -1; f_bits = 0; f_prev = 1'b0;
      end else begin
        f_cyc++;
        if (f_clk && !f_prev) begin
          if (f_bits == 0) begin
            if (f_frames > 0) check("fast_frame_gap", 64'(f_cyc - f_last), 64'd5);
            f_space_ok = 1'b1;
          end else if (f_cyc - f_last != 2) begin
            f_space_ok = 1'b0;
          end
          f_last = f_cyc;
          f_sh = {f_sh[62:0], f_dt};
          f_bits++;
          if (f_bits == 64) begin
            check("fast_bit_spacing", 64'(f_space_ok), 64'd1);
            if (exp_f.size() == 0) begin
              checks++; errors++;
              $display("FAIL fast_frame: got unexpected frame %h, expected none", f_sh);
            end else begin
              check("fast_frame", f_sh, exp_f.pop_front());
            end
            f_bits = 0;
            f_frames++;
          end
        end
        f_prev = f_clk;
      end
    end
  end

  int now;
  task automatic wait_until(input int c);
    while (now < c) begin
      @(posedge clk);
      now++;
    end
    #2;
  endtask

  initial begin
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("rst_segclk", 64'(s_clk), 64'd0);
    check("rst_segdt", 64'(s_dt), 64'd0);
    check("rst_segclr", 64'(s_clr), 64'd0);
    check("rst_segen", 64'(s_en), 64'd0);
    check("rst_fast_segclr", 64'(f_clr), 64'd0);

    exp_s.push_back(FR_ZERO);
    exp_s.push_back(FR_ONE);
    exp_f.push_back(FR_ZERO);
    exp_f.push_back(FR_TWO);
    exp_f.push_back(FR_FIVE);
    exp_f.push_back(FR_SEVN);
    rst = 1'b1;
    now = -1;

    wait_until(20);
    check("segclr_released", 64'(s_clr), 64'd1);
    check("segen_before_first_done", 64'(s_en), 64'd0);

    // Hold a value across the tick at edge 1999 so the next LOAD snapshots it.
    wait_until(1499);
    exp_s.push_back(FR_MIX);
    force dut_s.value_q = 32'h89AB_CDEF;
    wait_until(2009);
    release dut_s.value_q;

    wait_until(2499);
    exp_s.push_back(FR_FFFF);
    force dut_s.value_q = 32'hFFFF_FFFF;
    wait_until(3009);
    release dut_s.value_q;
    exp_s.push_back(FR_ZERO);

    // Frame for value 1 starts at cycle 5000; abort it at its 30th bit.
    wait_until(5009);
    for (int i = 0; i < 300 && s_bits != 30; i++) begin
      @(negedge clk);
      #1;
    end
    check("reached_bit_30", 64'(s_bits), 64'd30);
    @(posedge clk);
    #2;
    check("segen_before_abort", 64'(s_en), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_segclk", 64'(s_clk), 64'd0);
    check("abort_segdt", 64'(s_dt), 64'd0);
    check("abort_segclr", 64'(s_clr), 64'd0);
    check("abort_segen", 64'(s_en), 64'd0);

    repeat (3) @(posedge clk);
    #2;
    exp_s.push_back(FR_ZERO);
    rst = 1'b1;

    for (int i = 0; i < 400 && exp_s.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    check("slow_queue_drained", 64'(exp_s.size()), 64'd0);
    check("fast_queue_drained", 64'(exp_f.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
